// File: rtl/color_detector.sv
// Colour detector: steps a TCS3200-style sensor through its four filters,
// counts output pulses per filter and classifies the result.
module color_detector #(
    parameter int SETTLE_CYCLES = 100,
    parameter int GATE_CYCLES   = 10000,
    parameter int CNT_W         = 16,
    parameter int MIN_CLEAR     = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startDetection,
    input  logic [3:0] sensorSelect,
    input  logic       sensorOut,
    output logic [1:0] filterSelect,
    output logic       busy,
    output logic       detectionComplete,
    output logic [2:0] colorCode,
    output logic [3:0] resultSensor
);

    localparam int TMAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0]  L_SET_END  = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]  L_GATE_END = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W:0] L_MIN_CLR  = (CNT_W + 1)'(MIN_CLEAR);

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_GATE, S_NEXT, S_CLASSIFY, S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_sync;
    logic              r_prev;
    logic              w_edge;
    logic [TW-1:0]     r_timer;
    logic [1:0]        r_ch;
    logic [CNT_W-1:0]  r_cnt [4];
    logic [2:0]        r_color;
    logic [3:0]        r_sensor;
    logic              w_start;
    logic [CNT_W:0]    w_r;
    logic [CNT_W:0]    w_g;
    logic [CNT_W:0]    w_b;
    logic [CNT_W:0]    w_c;
    logic [CNT_W:0]    w_b2;
    logic [CNT_W:0]    w_g2;
    logic [2:0]        w_code;

    assign w_start = (r_state == S_IDLE) && startDetection;
    assign w_edge  = r_sync[1] & ~r_prev;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (startDetection) w_next = S_SETTLE;
            S_SETTLE:   if (r_timer == L_SET_END) w_next = S_GATE;
            S_GATE:     if (r_timer == L_GATE_END) w_next = S_NEXT;
            S_NEXT:     w_next = (r_ch == 2'd3) ? S_CLASSIFY : S_SETTLE;
            S_CLASSIFY: w_next = S_DONE;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy              = (r_state != S_IDLE) && (r_state != S_DONE);
        detectionComplete = (r_state == S_DONE);
        colorCode         = r_color;
        resultSensor      = r_sensor;
        unique case (r_ch)
            2'd0: filterSelect = 2'b00;
            2'd1: filterSelect = 2'b11;
            2'd2: filterSelect = 2'b01;
            2'd3: filterSelect = 2'b10;
        endcase
    end

    // Two-flop synchroniser plus previous sample for rising-edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], sensorOut};
            r_prev <= r_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if ((r_state == S_SETTLE && r_timer != L_SET_END) ||
                     (r_state == S_GATE && r_timer != L_GATE_END)) begin
            r_timer <= r_timer + TW'(1);
        end else begin
            r_timer <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch     <= 2'd0;
            r_sensor <= 4'd0;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (w_start) begin
            r_ch     <= 2'd0;
            r_sensor <= sensorSelect;
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else begin
            if (r_state == S_NEXT && r_ch != 2'd3) r_ch <= r_ch + 2'd1;
            // Saturate rather than wrap so a bright channel stays bright
            if (r_state == S_GATE && w_edge && r_cnt[r_ch] != '1)
                r_cnt[r_ch] <= r_cnt[r_ch] + CNT_W'(1);
        end
    end

    assign w_r  = {1'b0, r_cnt[0]};
    assign w_g  = {1'b0, r_cnt[1]};
    assign w_b  = {1'b0, r_cnt[2]};
    assign w_c  = {1'b0, r_cnt[3]};
    assign w_b2 = {r_cnt[2], 1'b0};
    assign w_g2 = {r_cnt[1], 1'b0};

    always_comb begin
        w_code = 3'd3;
        if (w_c < L_MIN_CLR)                             w_code = 3'd0;
        else if (w_r > w_b2 && w_g > w_b2 && w_g2 > w_r) w_code = 3'd4;
        else if (w_r >= w_g && w_r >= w_b)               w_code = 3'd1;
        else if (w_g >= w_b)                             w_code = 3'd2;
    end

    always_ff @(posedge clk) begin
        if (reset)                      r_color <= 3'd0;
        else if (r_state == S_CLASSIFY) r_color <= w_code;
    end

endmodule

// File: tb/tb_color_detector.sv
// Self-checking bench for color_detector.
// Directed and random per-filter counts vs model.
module tb_color_detector;

  localparam int S  = 4;
  localparam int G  = 200;
  localparam int MC = 8;
  localparam int P  = S + G + 1;
  localparam int L  = 4 * (S + G) + 5;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       startDetection = 1'b0;
  logic [3:0] sensorSelect = 4'd0;
  logic       sensorOut = 1'b0;

  logic [1:0] fs, fs_n;
  logic       busy, busy_n;
  logic       dc, dc_n;
  logic [2:0] cc, cc_n;
  logic [3:0] rs, rs_n;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  color_detector #(
    .SETTLE_CYCLES(S), .GATE_CYCLES(G),
    .CNT_W(16), .MIN_CLEAR(MC)
  ) dut (
    .clk(clk), .reset(reset),
    .startDetection(startDetection),
    .sensorSelect(sensorSelect),
    .sensorOut(sensorOut),
    .filterSelect(fs), .busy(busy),
    .detectionComplete(dc),
    .colorCode(cc), .resultSensor(rs)
  );

  color_detector #(
    .SETTLE_CYCLES(S), .GATE_CYCLES(G),
    .CNT_W(4), .MIN_CLEAR(MC)
  ) dut_n (
    .clk(clk), .reset(reset),
    .startDetection(startDetection),
    .sensorSelect(sensorSelect),
    .sensorOut(sensorOut),
    .filterSelect(fs_n), .busy(busy_n),
    .detectionComplete(dc_n),
    .colorCode(cc_n), .resultSensor(rs_n)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic int classify(
    input int r, g, b, c, input int cap);
    if (r > cap) r = cap;
    if (g > cap) g = cap;
    if (b > cap) b = cap;
    if (c > cap) c = cap;
    if (c < MC) return 0;
    if (r > 2 * b && g > 2 * b && 2 * g > r)
      return 4;
    if (r >= g && r >= b) return 1;
    if (g >= b) return 2;
    return 3;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals();
    chk("rst_fs", 32'(fs), 32'(2'b00));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_dc", 32'(dc), 32'(1'b0));
    chk("rst_cc", 32'(cc), 32'(3'd0));
    chk("rst_rs", 32'(rs), 32'(4'd0));
    chk("rst_cc_n", 32'(cc_n), 32'(3'd0));
    chk("rst_dc_n", 32'(dc_n), 32'(1'b0));
  endtask

  task automatic run_det(
    input logic [3:0] sel, input int r, g, b, c,
    input bit mid_start, input int abort_t);
    int cnt[4];
    logic [1:0] enc[4];
    logic [2:0] exp_w, exp_n;
    cnt = '{r, g, b, c};
    enc = '{2'b00, 2'b11, 2'b01, 2'b10};
    exp_w = 3'(classify(r, g, b, c, 65535));
    exp_n = 3'(classify(r, g, b, c, 15));
    startDetection = 1'b1;
    sensorSelect = sel;
    step();
    startDetection = 1'b0;
    sensorSelect = ~sel;
    for (int t = 0; t <= L + 1; t++) begin
      int ch, w;
      ch = t / P;
      w = t % P;
      if (t == abort_t) begin
        sensorOut = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_vals();
        for (int k = 0; k < L + 20; k++) begin
          step();
          chk("abort_dc", 32'(dc), 32'(1'b0));
          chk("abort_busy", 32'(busy), 32'(1'b0));
        end
        return;
      end
      sensorOut = 1'b0;
      if (ch < 4 && w >= S &&
          (w - S) < 4 * cnt[ch])
        sensorOut = ((w - S) % 4) < 2;
      startDetection = mid_start &&
        (t == P + S + 20 || t == L);
      chk("dc_timing", 32'(dc), 32'(t == L));
      chk("busy", 32'(busy), 32'(t < L));
      chk("dc_n_timing", 32'(dc_n),
          32'(t == L));
      if (ch < 4 && w == S + G / 2) begin
        chk("filter", 32'(fs), 32'(enc[ch]));
        chk("filter_n", 32'(fs_n),
            32'(enc[ch]));
      end
      if (t == L) begin
        chk("color", 32'(cc), 32'(exp_w));
        chk("color_sat", 32'(cc_n),
            32'(exp_n));
        chk("sensor", 32'(rs), 32'(sel));
        chk("sensor_n", 32'(rs_n), 32'(sel));
        chk("fs_hold", 32'(fs), 32'(2'b10));
      end
      step();
    end
    startDetection = 1'b0;
    chk("idle_fs_hold", 32'(fs), 32'(2'b10));
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check_reset_vals();
      step();
    end

    run_det(4'd5, 20, 5, 4, 30, 1'b0, -1);
    run_det(4'd1, 20, 18, 5, 40, 1'b0, -1);
    run_det(4'd2, 20, 9, 5, 40, 1'b0, -1);
    run_det(4'd3, 30, 30, 30, 3, 1'b0, -1);
    run_det(4'd4, 2, 2, 30, 40, 1'b0, -1);
    run_det(4'd6, 3, 12, 10, 20, 1'b0, -1);
    run_det(4'd7, 10, 40, 6, 45, 1'b1, -1);
    run_det(4'd9, 10, 40, 6, 45, 1'b0,
            P + S + 20);
    run_det(4'd10, 16, 30, 2, 44, 1'b0, -1);

    for (int i = 0; i < 12; i++) begin
      run_det(4'(i),
              int'($urandom_range(45, 0)),
              int'($urandom_range(45, 0)),
              int'($urandom_range(45, 0)),
              int'($urandom_range(45, 0)),
              1'b0, -1);
      step();
    end
    chk("sel_done_busy", 32'(busy), 32'(1'b0));

    $display(
      "End of test - %0d assertions evaluated, %0d failures",
      n_chk, n_fail);
    $finish;
  end

endmodule
